// File: rtl/clk_seq_pkg.sv
// Shared types and default constants for the clocking-wizard reset sequencer.
package clk_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } clk_seq_state_t;

  localparam int DEF_RST_CYCLES     = 16;
  localparam int DEF_LOCK_TIMEOUT   = 1024;
  localparam int DEF_SETTLE_CYCLES  = 64;
  localparam int DEF_RELEASE_CYCLES = 4;
  localparam int DEF_MAX_RETRIES    = 3;
  localparam int LOCK_LOSS_MAX      = 255;

  // Largest of the timing parameters; sizes the shared phase counter.
  function automatic int max_param(input int a, input int b, input int c,
                                   input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/clk_seq_sync.sv
// Two-flop synchronizer for the MMCM locked flag; clears to 0 on reset.
module clk_seq_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage resynchronization of d into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/clk_wiz_reset_seq.sv
// Power-up / recovery sequencer for an MMCM and the BUFGCEs it feeds.
// Optional feature macro: CLK_SEQ_LOCK_SYNC_EN (adds a 2-flop synchronizer
// on `locked`; without it `locked` is used directly).
module clk_wiz_reset_seq
  import clk_seq_pkg::*;
#(
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  input  logic       restart,
  output logic       mmcm_reset,
  output logic       clk_en,
  output logic       rst_out,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retries,
  output logic [7:0] lock_loss_cnt
);

  localparam int CNT_W = $clog2(max_param(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES,
                                          RELEASE_CYCLES, MAX_RETRIES)) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);
  localparam logic [7:0]       LOSS_MAX     = 8'(LOCK_LOSS_MAX);

  clk_seq_state_t   state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [1:0]       retries_r, retries_nxt_s;
  logic [7:0]       loss_r, loss_nxt_s;
  logic             mmcm_reset_r, clk_en_r, rst_out_r, ready_r, fault_r;
  logic             mmcm_reset_nxt_s, clk_en_nxt_s, rst_out_nxt_s, ready_nxt_s, fault_nxt_s;
  logic             locked_s;

`ifdef CLK_SEQ_LOCK_SYNC_EN
  clk_seq_sync u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (locked),
    .q     (locked_s)
  );
`else
  assign locked_s = locked;
`endif

  // Next-state, phase counter, retry and lock-loss bookkeeping.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    retries_nxt_s = retries_r;
    loss_nxt_s    = loss_r;
    if (restart) begin
      state_nxt_s   = ST_RST;
      cnt_nxt_s     = CNT_ZERO;
      retries_nxt_s = 2'd0;
    end else begin
      case (state_r)
        ST_RST: begin
          if (cnt_r == RST_LAST) begin
            state_nxt_s = ST_WAIT_LOCK;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt_s = ST_SETTLE;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == TIMEOUT_LAST) begin
            cnt_nxt_s = CNT_ZERO;
            if (retries_r < RETRY_MAX) begin
              retries_nxt_s = retries_r + 2'd1;
              state_nxt_s   = ST_RST;
            end else begin
              state_nxt_s = ST_FAULT;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_SETTLE: begin
          if (!locked_s) begin
            state_nxt_s = ST_WAIT_LOCK;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == SETTLE_LAST) begin
            state_nxt_s = ST_RELEASE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_RELEASE, ST_RUN: begin
          // Lock loss in RELEASE is handled exactly like a loss in RUN.
          if (!locked_s) begin
            state_nxt_s   = ST_RST;
            cnt_nxt_s     = CNT_ZERO;
            retries_nxt_s = 2'd0;
            loss_nxt_s    = (loss_r == LOSS_MAX) ? loss_r : loss_r + 8'd1;
          end else if (state_r == ST_RELEASE && cnt_r == RELEASE_LAST) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = CNT_ZERO;
          end else if (state_r == ST_RELEASE) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        ST_FAULT: begin
          state_nxt_s = ST_FAULT;
        end
        default: begin
          state_nxt_s = ST_RST;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output values decoded from the state being entered, so they register with it.
  always_comb begin
    mmcm_reset_nxt_s = 1'b1;
    clk_en_nxt_s     = 1'b0;
    rst_out_nxt_s    = 1'b1;
    ready_nxt_s      = 1'b0;
    fault_nxt_s      = 1'b0;
    case (state_nxt_s)
      ST_RST:       mmcm_reset_nxt_s = 1'b1;
      ST_WAIT_LOCK,
      ST_SETTLE:    mmcm_reset_nxt_s = 1'b0;
      ST_RELEASE: begin
        mmcm_reset_nxt_s = 1'b0;
        clk_en_nxt_s     = 1'b1;
      end
      ST_RUN: begin
        mmcm_reset_nxt_s = 1'b0;
        clk_en_nxt_s     = 1'b1;
        rst_out_nxt_s    = 1'b0;
        ready_nxt_s      = 1'b1;
      end
      ST_FAULT:     fault_nxt_s = 1'b1;
      default:      mmcm_reset_nxt_s = 1'b1;
    endcase
  end

  // State, counters and registered outputs; reset forces safe values at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_RST;
      cnt_r        <= CNT_ZERO;
      retries_r    <= 2'd0;
      loss_r       <= 8'd0;
      mmcm_reset_r <= 1'b1;
      clk_en_r     <= 1'b0;
      rst_out_r    <= 1'b1;
      ready_r      <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      retries_r    <= retries_nxt_s;
      loss_r       <= loss_nxt_s;
      mmcm_reset_r <= mmcm_reset_nxt_s;
      clk_en_r     <= clk_en_nxt_s;
      rst_out_r    <= rst_out_nxt_s;
      ready_r      <= ready_nxt_s;
      fault_r      <= fault_nxt_s;
    end
  end

  assign mmcm_reset    = mmcm_reset_r;
  assign clk_en        = clk_en_r;
  assign rst_out       = rst_out_r;
  assign ready         = ready_r;
  assign fault         = fault_r;
  assign retries       = retries_r;
  assign lock_loss_cnt = loss_r;

endmodule
